// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers (shift-add multiplier, restoring divider).
// Arithmetic ops take NB_DATA+2 cycles from accept to o_done; MTHI/MTLO complete in one.
module alu_muldiv #(
  parameter int NB_DATA      = 32,
  parameter int NB_OPERATION = 3
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [NB_OPERATION-1:0] i_op,
  input  logic [NB_DATA-1:0]      i_data_a,
  input  logic [NB_DATA-1:0]      i_data_b,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [NB_DATA-1:0]      o_hi,
  output logic [NB_DATA-1:0]      o_lo
);

  localparam int NB_COUNT = $clog2(NB_DATA + 1);

  localparam logic [NB_OPERATION-1:0] OP_MULT  = NB_OPERATION'(0);
  localparam logic [NB_OPERATION-1:0] OP_MULTU = NB_OPERATION'(1);
  localparam logic [NB_OPERATION-1:0] OP_DIV   = NB_OPERATION'(2);
  localparam logic [NB_OPERATION-1:0] OP_DIVU  = NB_OPERATION'(3);
  localparam logic [NB_OPERATION-1:0] OP_MTHI  = NB_OPERATION'(4);
  localparam logic [NB_OPERATION-1:0] OP_MTLO  = NB_OPERATION'(5);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [2*NB_DATA-1:0]   acc;
  logic [NB_DATA-1:0]     operand;
  logic [NB_DATA-1:0]     hi;
  logic [NB_DATA-1:0]     lo;
  logic [NB_COUNT-1:0]    count;
  logic                   is_mul;
  logic                   sign_a;
  logic                   sign_b;
  logic                   div_zero;
  logic                   done;

  logic                   in_mul;
  logic                   in_div;
  logic                   in_signed;
  logic                   in_sign_a;
  logic                   in_sign_b;
  logic                   accept;
  logic [NB_DATA-1:0]     in_mag_a;
  logic [NB_DATA-1:0]     in_mag_b;

  assign in_mul    = (i_op == OP_MULT) || (i_op == OP_MULTU);
  assign in_div    = (i_op == OP_DIV)  || (i_op == OP_DIVU);
  assign in_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign in_sign_a = in_signed && i_data_a[NB_DATA-1];
  assign in_sign_b = in_signed && i_data_b[NB_DATA-1];
  assign in_mag_a  = in_sign_a ? -i_data_a : i_data_a;
  assign in_mag_b  = in_sign_b ? -i_data_b : i_data_b;
  assign accept    = (state == IDLE) && i_start;

  // One iteration of each datapath; acc holds {partial, multiplier} or {remainder, dividend/quotient}.
  logic [NB_DATA:0]       mul_sum;
  logic [NB_DATA+1:0]     div_trial;
  logic                   div_ge;
  logic [NB_DATA-1:0]     div_rem;

  assign mul_sum   = {1'b0, acc[2*NB_DATA-1:NB_DATA]} +
                     (acc[0] ? {1'b0, operand} : {(NB_DATA+1){1'b0}});
  assign div_trial = {1'b0, acc[2*NB_DATA-1:NB_DATA], acc[NB_DATA-1]} - {2'b00, operand};
  assign div_ge    = ~div_trial[NB_DATA+1];
  assign div_rem   = div_ge ? div_trial[NB_DATA-1:0] : {acc[2*NB_DATA-2:NB_DATA], acc[NB_DATA-1]};

  logic [2*NB_DATA-1:0]   prod;
  logic [NB_DATA-1:0]     quot;
  logic [NB_DATA-1:0]     rem;
  logic [NB_DATA-1:0]     fix_hi;
  logic [NB_DATA-1:0]     fix_lo;

  always_comb begin
    prod   = (sign_a ^ sign_b) ? -acc : acc;
    quot   = (sign_a ^ sign_b) ? -acc[NB_DATA-1:0] : acc[NB_DATA-1:0];
    rem    = sign_a ? -acc[2*NB_DATA-1:NB_DATA] : acc[2*NB_DATA-1:NB_DATA];
    fix_hi = rem;
    fix_lo = quot;
    if (is_mul) begin
      fix_hi = prod[2*NB_DATA-1:NB_DATA];
      fix_lo = prod[NB_DATA-1:0];
    end else if (div_zero) begin
      fix_hi = operand;
      fix_lo = '1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start && (in_mul || in_div)) state_next = CALC;
      CALC:    if (count == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      acc      <= '0;
      operand  <= '0;
      count    <= '0;
      is_mul   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && in_mul) begin
            acc      <= {{NB_DATA{1'b0}}, in_mag_b};
            operand  <= in_mag_a;
            count    <= NB_COUNT'(NB_DATA - 1);
            is_mul   <= 1'b1;
            sign_a   <= in_sign_a;
            sign_b   <= in_sign_b;
            div_zero <= 1'b0;
          end else if (accept && in_div) begin
            acc      <= {{NB_DATA{1'b0}}, in_mag_a};
            // On divide by zero the divisor slot carries the raw dividend, which becomes HI.
            operand  <= (i_data_b == '0) ? i_data_a : in_mag_b;
            count    <= NB_COUNT'(NB_DATA - 1);
            is_mul   <= 1'b0;
            sign_a   <= in_sign_a;
            sign_b   <= in_sign_b;
            div_zero <= (i_data_b == '0);
          end else if (accept) begin
            if (i_op == OP_MTHI) hi <= i_data_a;
            if (i_op == OP_MTLO) lo <= i_data_a;
            done <= 1'b1;
          end
        end
        CALC: begin
          acc   <= is_mul ? {mul_sum, acc[NB_DATA-1:1]}
                          : {div_rem, acc[NB_DATA-2:0], div_ge};
          count <= count - 1'b1;
        end
        FIX: begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (state != IDLE);
  assign o_done = done;
  assign o_hi   = hi;
  assign o_lo   = lo;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed and randomised checks of alu_muldiv against hand-computed values and a native-arithmetic model.
module tb_alu_muldiv;

  localparam logic [2:0] MULT  = 3'd0;
  localparam logic [2:0] MULTU = 3'd1;
  localparam logic [2:0] DIV   = 3'd2;
  localparam logic [2:0] DIVU  = 3'd3;
  localparam logic [2:0] MTHI  = 3'd4;
  localparam logic [2:0] MTLO  = 3'd5;
  localparam logic [2:0] RSVD  = 3'd6;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  alu_muldiv #(.NB_DATA(32), .NB_OPERATION(3)) dut (
    .i_clock  (clk),
    .i_reset  (rst),
    .i_start  (start),
    .i_op     (op),
    .i_data_a (a),
    .i_data_b (b),
    .o_busy   (busy),
    .o_done   (done),
    .o_hi     (hi),
    .o_lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("timeout", 0, 1);
  endtask

  // Leaves the bench in the o_done cycle so a following op can be issued back-to-back.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int busy_n);
    start_op(o, x, y);
    check("busy_after_accept", busy, 1);
    busy_n = busy ? 1 : 0;
    lat = 1;
    while (!done && lat < 200) begin
      tick();
      lat++;
      if (busy) busy_n++;
    end
    if (lat >= 200) check("timeout", 0, 1);
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] rh, output logic [31:0] rl);
    logic signed [63:0] sp;
    logic [63:0] up;
    int ix, iy;
    ix = x; iy = y;
    rh = 0; rl = 0;
    case (o)
      MULT: begin
        sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        rh = sp[63:32]; rl = sp[31:0];
      end
      MULTU: begin
        up = {32'd0, x} * {32'd0, y};
        rh = up[63:32]; rl = up[31:0];
      end
      DIV: begin
        if (y == 0) begin rh = x; rl = 32'hFFFF_FFFF; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin rh = 0; rl = 32'h8000_0000; end
        else begin rl = ix / iy; rh = ix % iy; end
      end
      default: begin
        if (y == 0) begin rh = x; rl = 32'hFFFF_FFFF; end
        else begin rl = x / y; rh = x % y; end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] corner [5];
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 1) == 0) return corner[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    int lat, busy_n, n;
    logic [31:0] eh, el;
    bit saw_done;

    rst = 1'b1; start = 1'b0; op = 3'd0; a = 0; b = 0;
    tick(); tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    rst = 1'b0;
    tick();

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busy_n);
    check("multu_latency", lat, 34);
    check("multu_busy_cycles", busy_n, 33);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    tick();
    check("done_one_cycle", done, 0);

    run_op(MULT, 32'hFFFF_FFFD, 32'd7, lat, busy_n);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, lat, busy_n);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    run_op(DIVU, 32'd7, 32'd2, lat, busy_n);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);
    run_op(DIVU, 32'd7, 32'd0, lat, busy_n);
    check("divu0_hi", hi, 32'd7);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    run_op(DIV, 32'hFFFF_FFF9, 32'd0, lat, busy_n);
    check("div0_hi", hi, 32'hFFFF_FFF9);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy_n);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'h0);
    tick();

    // MTLO and a second start while busy must both be ignored.
    start_op(MULT, 32'd5, 32'd6);
    tick(); tick(); tick();
    start_op(MTLO, 32'h1234, 0);
    check("mtlo_busy_no_done", done, 0);
    start_op(DIVU, 32'd9, 32'd3);
    wait_done(n);
    check("busy_ignore_latency", n + 6, 34);
    check("busy_ignore_hi", hi, 32'd0);
    check("busy_ignore_lo", lo, 32'd30);
    tick();
    start_op(MTHI, 32'hABCD, 0);
    check("mthi_hi", hi, 32'hABCD);
    check("mthi_done", done, 1);
    check("mthi_busy", busy, 0);
    check("mthi_lo", lo, 32'd30);
    tick();
    check("mthi_done_pulse", done, 0);
    start_op(RSVD, 32'h5555, 32'h6666);
    check("rsvd_done", done, 1);
    check("rsvd_hi", hi, 32'hABCD);
    check("rsvd_lo", lo, 32'd30);
    tick();

    // Asynchronous reset ten cycles into a divide.
    start_op(DIV, 32'd100, 32'd7);
    repeat (9) tick();
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    tick(); tick();
    rst = 1'b0;
    saw_done = 0;
    repeat (40) begin
      tick();
      if (done) saw_done = 1;
    end
    check("arst_no_done", saw_done, 0);
    run_op(MULT, 32'h7FFF_FFFF, 32'd2, lat, busy_n);
    check("post_reset_latency", lat, 34);
    check("post_reset_hi", hi, 32'h0);
    check("post_reset_lo", lo, 32'hFFFF_FFFE);

    // Back-to-back: each op issued in the previous op's o_done cycle.
    for (int i = 0; i < 24; i++) begin
      logic [2:0] ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      model(ro, ra, rb, eh, el);
      run_op(ro, ra, rb, lat, busy_n);
      check($sformatf("rand%0d_op%0d_latency", i, ro), lat, 34);
      check($sformatf("rand%0d_op%0d_a%h_b%h_hi", i, ro, ra, rb), hi, eh);
      check($sformatf("rand%0d_op%0d_a%h_b%h_lo", i, ro, ra, rb), lo, el);
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
